// File: rtl/cp0_exception_unit.sv
// CP0 exception/return controller: Status/Cause/EPC, exception redirect, eret and mtc0/mfc0.
// Optional Count/Compare timer is compiled in when CP0_TIMER_EN is defined.
module cp0_exception_unit #(
  parameter logic [31:0] HANDLER_ADDR = 32'h8000_0180,
  parameter int          NUM_IRQ      = 6
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [31:0]        i_pc,
  input  logic               i_unknown_func,
  input  logic               i_arithmetic_overflow,
  input  logic               i_eret,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic               i_cp0_we,
  input  logic [4:0]         i_cp0_addr,
  input  logic [31:0]        i_cp0_wdata,
  output logic [31:0]        o_cp0_rdata,
  output logic               o_exception,
  output logic               o_kill,
  output logic               o_redirect,
  output logic [31:0]        o_redirect_pc,
  output logic               o_exl
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  typedef enum logic {RUN = 1'b0, HANDLER = 1'b1} state_t;

  state_t      r_state;
  logic [7:0]  r_im;
  logic        r_ie;
  logic [5:0]  r_ip_hw;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_valid;
  logic        w_exl;
  logic        w_ri;
  logic        w_ov;
  logic        w_eret_ok;
  logic        w_int;
  logic        w_exc;
  logic        w_wr;
  logic [4:0]  w_code;
  logic [5:0]  w_ip_hw;
  logic [7:0]  w_ip;
  logic [5:0]  w_irq_ext;

`ifdef CP0_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_timer_ip;
  assign w_ip_hw = {r_timer_ip, r_ip_hw[4:0]};
`else
  assign w_ip_hw = r_ip_hw;
`endif

  assign w_irq_ext = 6'(i_irq);
  assign w_exl     = (r_state == HANDLER);
  assign w_ip      = {w_ip_hw, r_ip_sw};
  // Reset suppresses every instruction event so outputs stay quiet while it is held.
  assign w_valid   = i_valid & ~i_rst;

  always_comb begin
    w_ri      = w_valid & (i_unknown_func | (i_eret & ~w_exl));
    w_ov      = w_valid & i_arithmetic_overflow & ~w_ri;
    w_eret_ok = w_valid & i_eret & w_exl & ~i_unknown_func & ~i_arithmetic_overflow;
    w_int     = w_valid & r_ie & ~w_exl & (|(w_ip & r_im)) & ~w_ri & ~w_ov & ~w_eret_ok;
    w_exc     = w_ri | w_ov | w_int;
    w_code    = w_ri ? EXC_RI : (w_ov ? EXC_OV : EXC_INT);
    w_wr      = w_valid & i_cp0_we & ~w_exc;
  end

  assign o_exception   = w_exc;
  assign o_kill        = w_exc;
  assign o_redirect    = w_exc | w_eret_ok;
  assign o_redirect_pc = w_exc ? HANDLER_ADDR : (w_eret_ok ? r_epc : 32'd0);
  assign o_exl         = w_exl;

  always_comb begin
    o_cp0_rdata = 32'd0;
    case (i_cp0_addr)
      ADDR_STATUS: o_cp0_rdata = {16'd0, r_im, 6'd0, w_exl, r_ie};
      ADDR_CAUSE:  o_cp0_rdata = {16'd0, w_ip, 1'b0, r_exccode, 2'b00};
      ADDR_EPC:    o_cp0_rdata = r_epc;
`ifdef CP0_TIMER_EN
      ADDR_COUNT:   o_cp0_rdata = r_count;
      ADDR_COMPARE: o_cp0_rdata = r_compare;
`endif
      default:     o_cp0_rdata = 32'd0;
    endcase
  end

  // EPC is captured only on entry from RUN so a nested fault keeps the original return point.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= RUN;
      r_im      <= 8'd0;
      r_ie      <= 1'b0;
      r_ip_hw   <= 6'd0;
      r_ip_sw   <= 2'd0;
      r_exccode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      r_ip_hw <= w_irq_ext;
      if (w_exc) begin
        r_exccode <= w_code;
        if (r_state == RUN) begin
          r_epc   <= i_pc;
          r_state <= HANDLER;
        end
      end else begin
        if (w_wr) begin
          case (i_cp0_addr)
            ADDR_STATUS: begin
              r_im    <= i_cp0_wdata[15:8];
              r_ie    <= i_cp0_wdata[0];
              r_state <= i_cp0_wdata[1] ? HANDLER : RUN;
            end
            ADDR_CAUSE: r_ip_sw <= i_cp0_wdata[9:8];
            ADDR_EPC:   r_epc   <= i_cp0_wdata;
            default: ;
          endcase
        end
        if (w_eret_ok) r_state <= RUN;
      end
    end
  end

`ifdef CP0_TIMER_EN
  // A Compare write acknowledges the timer interrupt, taking precedence over a fresh match.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count    <= 32'd0;
      r_compare  <= 32'd0;
      r_timer_ip <= 1'b0;
    end else begin
      if (w_wr && i_cp0_addr == ADDR_COUNT) r_count <= i_cp0_wdata;
      else                                  r_count <= r_count + 32'd1;
      if (w_wr && i_cp0_addr == ADDR_COMPARE) begin
        r_compare  <= i_cp0_wdata;
        r_timer_ip <= 1'b0;
      end else if (r_count == r_compare) begin
        r_timer_ip <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed self-checking bench for cp0_exception_unit (default build; timer scenario when CP0_TIMER_EN is defined).
module tb_cp0_exception_unit;

  localparam logic [31:0] HANDLER = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] pc;
  logic        ufunc;
  logic        ovf;
  logic        eret;
  logic [5:0]  irq;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        exc;
  logic        kill;
  logic        redir;
  logic [31:0] redir_pc;
  logic        exl;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cp0_exception_unit #(.HANDLER_ADDR(HANDLER), .NUM_IRQ(6)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_pc(pc),
    .i_unknown_func(ufunc), .i_arithmetic_overflow(ovf), .i_eret(eret),
    .i_irq(irq), .i_cp0_we(we), .i_cp0_addr(addr), .i_cp0_wdata(wdata),
    .o_cp0_rdata(rdata), .o_exception(exc), .o_kill(kill), .o_redirect(redir),
    .o_redirect_pc(redir_pc), .o_exl(exl)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 0; ufunc = 0; ovf = 0; eret = 0; we = 0; addr = 5'd0; wdata = 32'd0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    valid = 1; we = 1; addr = a; wdata = d;
    step();
    idle();
  endtask

  task automatic read_reg(input logic [4:0] a, input logic [31:0] exp, input string name);
    addr = a;
    #1;
    vectors++;
    if (rdata !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, rdata, exp);
    end
  endtask

  task automatic test_reset();
    idle(); irq = 0; pc = 0; rst = 1;
    step(); step();
    vectors++;
    if ({exc, kill, redir, exl} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b expected 0000", {exc, kill, redir, exl});
    end
    vectors++;
    if (redir_pc !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_redirect_pc: got %h expected 00000000", redir_pc);
    end
    read_reg(5'd12, 32'd0, "reset_status");
    read_reg(5'd13, 32'd0, "reset_cause");
    read_reg(5'd14, 32'd0, "reset_epc");
    rst = 0;
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer();
    int n;
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    mtc0(5'd12, 32'h0000_8001);
    valid = 1; pc = 32'h0040_0040;
    n = 0;
    while (exc !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (exc !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timer_irq: got exception %b expected 1 within 20 cycles", exc);
    end
    step(); idle();
    read_reg(5'd13, 32'h0000_8000, "timer_cause_ip7");
    mtc0(5'd11, 32'hFFFF_FFFF);
    read_reg(5'd13, 32'h0000_0000, "timer_ip7_cleared");
    mtc0(5'd12, 32'd0);
  endtask
`endif

  task automatic test_overflow();
    valid = 1; pc = 32'h0040_0010; ovf = 1;
    #1;
    vectors++;
    if ({exc, kill, redir} !== 3'b111 || redir_pc !== HANDLER) begin
      miscompares++;
      $display("[TB] FAIL ov_redirect: got e/k/r=%b pc=%h expected 111 pc=%h", {exc, kill, redir}, redir_pc, HANDLER);
    end
    step(); idle();
    vectors++;
    if (exl !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ov_exl: got %b expected 1", exl);
    end
    read_reg(5'd14, 32'h0040_0010, "ov_epc");
    read_reg(5'd13, 32'h0000_0030, "ov_cause");
  endtask

  task automatic test_eret();
    valid = 1; pc = HANDLER; eret = 1;
    #1;
    vectors++;
    if ({exc, kill, redir} !== 3'b001 || redir_pc !== 32'h0040_0010) begin
      miscompares++;
      $display("[TB] FAIL eret_redirect: got e/k/r=%b pc=%h expected 001 pc=00400010", {exc, kill, redir}, redir_pc);
    end
    step(); idle();
    vectors++;
    if (exl !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL eret_exl: got %b expected 0", exl);
    end
  endtask

  task automatic test_eret_in_run();
    valid = 1; pc = 32'h0040_0014; eret = 1;
    #1;
    vectors++;
    if ({exc, kill, redir} !== 3'b111 || redir_pc !== HANDLER) begin
      miscompares++;
      $display("[TB] FAIL eret_run_exc: got e/k/r=%b pc=%h expected 111 pc=%h", {exc, kill, redir}, redir_pc, HANDLER);
    end
    step(); idle();
    read_reg(5'd13, 32'h0000_0028, "eret_run_cause");
    read_reg(5'd14, 32'h0040_0014, "eret_run_epc");
    valid = 1; eret = 1; pc = HANDLER;
    step(); idle();
  endtask

  task automatic test_interrupt();
    mtc0(5'd12, 32'h0000_0401);
    read_reg(5'd12, 32'h0000_0401, "int_status");
    irq = 6'b000001;
    step();
    read_reg(5'd13, 32'h0000_0428, "int_cause_ip2");
    valid = 1; pc = 32'h0040_0020;
    #1;
    vectors++;
    if (exc !== 1'b1 || redir_pc !== HANDLER) begin
      miscompares++;
      $display("[TB] FAIL int_taken: got exc=%b pc=%h expected 1 pc=%h", exc, redir_pc, HANDLER);
    end
    step(); idle();
    read_reg(5'd13, 32'h0000_0400, "int_cause_code");
    read_reg(5'd14, 32'h0040_0020, "int_epc");
    valid = 1; pc = HANDLER;
    #1;
    vectors++;
    if (exc !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL int_masked_exl: got %b expected 0", exc);
    end
    idle(); irq = 0;
    step();
    valid = 1; eret = 1;
    #1;
    vectors++;
    if (redir_pc !== 32'h0040_0020) begin
      miscompares++;
      $display("[TB] FAIL int_eret_pc: got %h expected 00400020", redir_pc);
    end
    step(); idle();
  endtask

  task automatic test_priority();
    valid = 1; pc = 32'h0040_0030; ufunc = 1; ovf = 1;
    step(); idle();
    read_reg(5'd13, 32'h0000_0028, "prio_ri_over_ov");
    read_reg(5'd14, 32'h0040_0030, "prio_epc");
  endtask

  task automatic test_ri_in_handler();
    valid = 1; pc = 32'h8000_0184; ovf = 1;
    step(); idle();
    read_reg(5'd13, 32'h0000_0030, "handler_ov_code");
    valid = 1; pc = 32'h8000_0188; ufunc = 1;
    #1;
    vectors++;
    if (redir_pc !== HANDLER || kill !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL handler_ri_redirect: got pc=%h kill=%b expected %h 1", redir_pc, kill, HANDLER);
    end
    step(); idle();
    read_reg(5'd13, 32'h0000_0028, "handler_ri_code");
    read_reg(5'd14, 32'h0040_0030, "handler_epc_kept");
    vectors++;
    if (exl !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL handler_exl: got %b expected 1", exl);
    end
  endtask

  task automatic test_killed_mtc0();
    valid = 1; pc = 32'h8000_018c; ufunc = 1; we = 1; addr = 5'd14; wdata = 32'hDEAD_BEEF;
    step(); idle();
    read_reg(5'd14, 32'h0040_0030, "killed_mtc0_epc");
    mtc0(5'd14, 32'h0040_0100);
    read_reg(5'd14, 32'h0040_0100, "mtc0_epc");
    valid = 1; eret = 1;
    #1;
    vectors++;
    if (redir_pc !== 32'h0040_0100) begin
      miscompares++;
      $display("[TB] FAIL eret_written_epc: got %h expected 00400100", redir_pc);
    end
    step(); idle();
  endtask

  task automatic test_invalid();
    valid = 0; ufunc = 1; ovf = 1; eret = 1; we = 1; addr = 5'd14; wdata = 32'h1234_5678;
    #1;
    vectors++;
    if ({exc, kill, redir} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL invalid_outputs: got %b expected 000", {exc, kill, redir});
    end
    step(); idle();
    read_reg(5'd14, 32'h0040_0100, "invalid_epc");
  endtask

  task automatic test_mtc0_misc();
    mtc0(5'd13, 32'hFFFF_FFFF);
    read_reg(5'd13, 32'h0000_0328, "cause_sw_bits");
    mtc0(5'd5, 32'hFFFF_FFFF);
    read_reg(5'd5, 32'd0, "unimpl_reg");
`ifndef CP0_TIMER_EN
    read_reg(5'd9, 32'd0, "count_absent");
`endif
    mtc0(5'd12, 32'h0000_0002);
    vectors++;
    if (exl !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL mtc0_exl_set: got %b expected 1", exl);
    end
    mtc0(5'd12, 32'h0000_0000);
    vectors++;
    if (exl !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mtc0_exl_clear: got %b expected 0", exl);
    end
  endtask

  task automatic test_reset_mid_handler();
    valid = 1; pc = 32'h0040_0200; ovf = 1;
    step();
    rst = 1; pc = 32'h0040_0204;
    #1;
    vectors++;
    if (redir !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_redirect: got %b expected 0", redir);
    end
    step(); idle(); rst = 0;
    vectors++;
    if (exl !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_exl: got %b expected 0", exl);
    end
    read_reg(5'd14, 32'd0, "reset_mid_epc");
  endtask

  initial begin
    test_reset();
`ifdef CP0_TIMER_EN
    test_timer();
`endif
    test_overflow();
    test_eret();
    test_eret_in_run();
    test_interrupt();
    test_priority();
    test_ri_in_handler();
    test_killed_mtc0();
    test_invalid();
    test_mtc0_misc();
    test_reset_mid_handler();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
